// File: rtl/lsu_load_ctrl_if.sv
// Load-controller bus bundle: request and response handshakes plus the data-memory read port.
// slave is the controller side; master is the pipeline/memory side.
interface lsu_load_ctrl_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_rd;
    logic              resp_misaligned;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_misaligned,
        input  resp_ready,
        output mem_en, mem_wr, mem_addr,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_misaligned,
        output resp_ready,
        input  mem_en, mem_wr, mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_load_ctrl.sv
// Load controller: accepts a load, issues one aligned doubleword read, extracts and
// extends the addressed field, and returns it with its register tag.
module lsu_load_ctrl #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    lsu_load_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]  load_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        rd_q;
    logic              mis_q;
    logic              req_ready;
    logic              accept;
    logic              req_mis;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extracted;

    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return |lo[1:0];
            default: return |lo;
        endcase
    endfunction

    assign req_mis = is_misaligned(bus.req_addr[2:0], bus.req_size);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic uses req_valid directly so req_ready stays a pure output of this block.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_en     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = req_mis ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                req_ready      = bus.resp_ready;
                if (bus.resp_ready) begin
                    if (bus.req_valid) state_d = req_mis ? RESP : ISSUE;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.req_valid & req_ready;

    always_comb begin
        shifted   = bus.mem_rdata >> {addr_q[2:0], 3'b000};
        extracted = shifted;
        case (size_q)
            2'd0: extracted = {{(DATA_W-8){~uns_q & shifted[7]}},   shifted[7:0]};
            2'd1: extracted = {{(DATA_W-16){~uns_q & shifted[15]}}, shifted[15:0]};
            2'd2: extracted = {{(DATA_W-32){~uns_q & shifted[31]}}, shifted[31:0]};
            default: extracted = shifted;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            data_q     <= '0;
            rd_q       <= '0;
            mis_q      <= 1'b0;
            load_count <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                size_q <= bus.req_size;
                uns_q  <= bus.req_unsigned;
                rd_q   <= bus.req_rd;
                mis_q  <= req_mis;
                data_q <= '0;
            end else if (state_q == ISSUE) begin
                data_q <= extracted;
                mis_q  <= 1'b0;
                if (load_count != '1) load_count <= load_count + 1'b1;
            end
        end
    end

    assign bus.req_ready       = req_ready;
    assign bus.resp_data       = data_q;
    assign bus.resp_rd         = rd_q;
    assign bus.resp_misaligned = mis_q;
    assign bus.mem_wr          = 1'b0;
    assign bus.mem_addr        = {addr_q[ADDR_W-1:3], 3'b000};
endmodule

// File: tb/tb_lsu_load_ctrl.sv
// Directed bench for lsu_load_ctrl; inputs change after the rising edge, outputs are sampled
// on the falling edge.
module tb_lsu_load_ctrl;
    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] load_count;
    int         checks = 0;
    int         errors = 0;

    lsu_load_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    lsu_load_ctrl #(.DATA_W(64), .ADDR_W(64), .CNT_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .load_count (load_count)
    );

    always #5 clock = ~clock;

    // Presents one request for a single cycle; returns at the falling edge of cycle N+1.
    task automatic send(input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_rd       = rd;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain();
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); end
        checks++; if (bus.mem_addr !== 64'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
        checks++; if (bus.resp_data !== 64'h0 || bus.resp_rd !== 5'd0 || bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL rst_resp_regs got %h/%0d/%b exp 0/0/0", bus.resp_data, bus.resp_rd, bus.resp_misaligned); end
        checks++; if (load_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", load_count); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL rst_ready got %b wr %b exp 1 0", bus.req_ready, bus.mem_wr); end
    endtask

    task automatic test_sign_byte();
        send(64'h8000_0007, 2'd0, 1'b0, 5'd3);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL byte_issue got en %b addr %h exp 1 80000000", bus.mem_en, bus.mem_addr); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL byte_early_valid got %b exp 0", bus.resp_valid); end
        @(negedge clock);
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL byte_en_one_cycle got %b exp 0", bus.mem_en); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FF88 || bus.resp_rd !== 5'd3 || bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL byte_resp got v%b %h rd%0d m%b exp v1 ffffffffffffff88 rd3 m0", bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_misaligned); end
        checks++; if (load_count !== 4'd1) begin errors++; $display("FAIL byte_count got %0d exp 1", load_count); end
        drain();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL byte_drain got v%b r%b exp v0 r1", bus.resp_valid, bus.req_ready); end
    endtask

    task automatic test_extract();
        send(64'h8000_0006, 2'd1, 1'b1, 5'd4);
        @(negedge clock);
        checks++; if (bus.resp_data !== 64'h0000_0000_0000_8877) begin errors++; $display("FAIL uhalf_data got %h exp 8877", bus.resp_data); end
        drain();
        send(64'h8000_0004, 2'd2, 1'b0, 5'd5);
        @(negedge clock);
        checks++; if (bus.resp_data !== 64'hFFFF_FFFF_8877_6655) begin errors++; $display("FAIL sword_data got %h exp ffffffff88776655", bus.resp_data); end
        drain();
        send(64'h8000_0002, 2'd1, 1'b0, 5'd6);
        @(negedge clock);
        checks++; if (bus.resp_data !== 64'h0000_0000_0000_4433) begin errors++; $display("FAIL shalf_pos_data got %h exp 4433", bus.resp_data); end
        drain();
        send(64'h8000_0000, 2'd3, 1'b1, 5'd8);
        @(negedge clock);
        checks++; if (bus.resp_data !== 64'h8877_6655_4433_2211) begin errors++; $display("FAIL dword_data got %h exp 8877665544332211", bus.resp_data); end
        checks++; if (load_count !== 4'd5) begin errors++; $display("FAIL extract_count got %0d exp 5", load_count); end
        drain();
    endtask

    task automatic test_misaligned();
        send(64'h8000_0002, 2'd2, 1'b0, 5'd11);
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL mis_mem_en got %b exp 0", bus.mem_en); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_misaligned !== 1'b1 || bus.resp_data !== 64'h0 || bus.resp_rd !== 5'd11) begin errors++; $display("FAIL mis_resp got v%b m%b %h rd%0d exp v1 m1 0 rd11", bus.resp_valid, bus.resp_misaligned, bus.resp_data, bus.resp_rd); end
        @(negedge clock);
        checks++; if (bus.mem_en !== 1'b0 || load_count !== 4'd5) begin errors++; $display("FAIL mis_no_access got en %b cnt %0d exp 0 5", bus.mem_en, load_count); end
        drain();
    endtask

    task automatic test_back_to_back();
        send(64'h8000_0008, 2'd3, 1'b0, 5'd7);
        checks++; if (bus.mem_addr !== 64'h8000_0008) begin errors++; $display("FAIL bp_addr got %h exp 80000008", bus.mem_addr); end
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rd !== 5'd7 || bus.resp_data !== 64'h8877_6655_4433_2211 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v%b rd%0d %h r%b exp v1 rd7 8877665544332211 r0", i, bus.resp_valid, bus.resp_rd, bus.resp_data, bus.req_ready); end
            @(negedge clock);
        end
        bus.resp_ready   = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_addr     = 64'h8000_0010;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b1;
        bus.req_rd       = 5'd9;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bus.req_ready); end
        @(posedge clock);
        #1 begin bus.resp_ready = 1'b0; bus.req_valid = 1'b0; end
        @(negedge clock);
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 64'h8000_0010 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue got en %b %h v%b exp 1 80000010 0", bus.mem_en, bus.mem_addr, bus.resp_valid); end
        @(negedge clock);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h11 || bus.resp_rd !== 5'd9) begin errors++; $display("FAIL b2b_resp got v%b %h rd%0d exp 1 11 9", bus.resp_valid, bus.resp_data, bus.resp_rd); end
        checks++; if (load_count !== 4'd7) begin errors++; $display("FAIL b2b_count got %0d exp 7", load_count); end
        drain();
    endtask

    task automatic test_reset_mid();
        send(64'h8000_0000, 2'd3, 1'b0, 5'd12);
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_en got %b exp 1", bus.mem_en); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.resp_valid !== 1'b0 || load_count !== 4'd0) begin errors++; $display("FAIL midrst_drop got en %b v%b cnt %0d exp 0 0 0", bus.mem_en, bus.resp_valid, load_count); end
        @(negedge clock);
        reset_n = 1'b1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (bus.resp_valid !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL midrst_quiet%0d got v%b en %b exp 0 0", i, bus.resp_valid, bus.mem_en); end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            send(64'h8000_0000 + 64'(i * 8), 2'd3, 1'b0, 5'(i));
            @(negedge clock);
            if (i == 13) begin
                checks++; if (load_count !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", load_count); end
            end
            drain();
        end
        checks++; if (load_count !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", load_count); end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.req_rd       = '0;
        bus.resp_ready   = 1'b0;
        bus.mem_rdata    = 64'h8877_6655_4433_2211;
        test_reset();
        test_sign_byte();
        test_extract();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_load_ctrl.md
Name: lsu_load_ctrl

Overview:
- Load-side controller of the memory-access stage. Sits directly upstream of the DPI-C data-memory read port.
- Accepts load requests from the execute/LSU pipeline over a valid/ready handshake and drives the read port with a doubleword-aligned address.
- Captures the port's combinational read data, then extracts the addressed byte/half/word/dword and sign- or zero-extends it.
- Returns the result with a register tag over a second valid/ready handshake. Misaligned loads are flagged without accessing memory.

Parameters:
- DATA_W, 64, data width; only 64 is supported.
- ADDR_W, 64, address width.
- CNT_W, 32, width of the saturating load-count performance counter.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  byte address of the load.
- req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- req_unsigned  in  1  1=zero-extend, 0=sign-extend.
- req_rd  in  5  destination register tag, returned unchanged.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  extended load result.
- resp_rd  out  5  tag of the returned load.
- resp_misaligned  out  1  load was misaligned; resp_data is 0.
- mem_en  out  1  read-port enable.
- mem_wr  out  1  read-port write flag; constant 0.
- mem_addr  out  ADDR_W  read-port address = {req_addr[ADDR_W-1:3], 3'b000}.
- mem_rdata  in  DATA_W  combinational read data from the port.
- load_count  out  CNT_W  number of completed memory reads, saturating.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, resp_misaligned=0, mem_en=0, mem_addr=0, load_count=0. Reset asserted mid-operation drops any pending request or response immediately; no mem_en is issued afterwards.
- Latched request: on acceptance, addr, size, unsigned and rd are registered. mem_addr comes from the latched address.
- IDLE state:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches the request.
  - Aligned request -> ISSUE.
  - Misaligned request (addr[0] for half, addr[1:0] for word, addr[2:0] for dword non-zero) -> RESP with resp_misaligned=1, resp_data=0, no mem_en pulse, load_count unchanged.
- ISSUE state:
  - mem_en=1 and mem_addr=aligned latched address for exactly one cycle.
  - At the edge, mem_rdata is shifted right by 8*addr[2:0], truncated to the size and extended, then registered into resp_data.
  - load_count increments, holding at all-ones.
  - Next state: RESP.
- RESP state:
  - resp_valid=1. resp_data, resp_rd and resp_misaligned are held stable while resp_ready=0.
  - req_ready=resp_ready.
  - resp_ready=1 with no new request -> IDLE.
  - resp_ready=1 with req_valid=1 -> the new request is latched in the same cycle (back-to-back). Next state is ISSUE, or RESP if that request is misaligned.
- mem_en is 0 in all states except ISSUE. mem_wr is always 0.
- Latency: request accepted at edge N; mem_en high during cycle N+1; resp_valid high from cycle N+2. Peak throughput is one load per 2 cycles. Misaligned load: resp_valid from cycle N+1.
- Extension: dword passes through unchanged. Sign-extension copies the MSB of the extracted field. req_unsigned is ignored for dword.

Test Plan:
- Sign-extended byte: mem_rdata=0x8877665544332211, byte at addr 0x80000007, signed -> resp_data=0xFFFFFFFFFFFFFF88; mem_addr=0x80000000; mem_en high exactly one cycle; resp_valid 2 cycles after acceptance.
- Unsigned half: same data, half at addr 0x80000006, unsigned -> resp_data=0x0000000000008877. Signed word at addr 0x80000004 -> 0xFFFFFFFF88776655.
- Misaligned word: word at addr 0x80000002 -> resp_misaligned=1, resp_data=0, mem_en never asserted, load_count unchanged.
- Backpressure and back-to-back:
  - Hold resp_ready=0 for 5 cycles -> resp_data, resp_rd=7 and resp_valid stable; req_ready=0.
  - Then raise resp_ready with a second request valid -> accepted in the same cycle; next mem_en is on the following cycle.
- Reset mid-operation: assert reset_n=0 asynchronously during ISSUE -> mem_en and resp_valid drop immediately, load_count=0; after release, req_ready=1 and no response appears.
- Counter saturation: with CNT_W=4, complete 17 aligned loads -> load_count reads 15.
